// File: rtl/iob_sync_asym_fifo.sv
// ============================================================================
// Module   : iob_sync_asym_fifo
// Purpose  : Single-clock FIFO with power-of-2 ratio between write and read
//            widths; storage, pointers and level counted in minimum words.
// Options  : IOB_FIFO_ALMOST_FLAGS_EN adds registered almost-full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_sync_asym_fifo #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 6
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int ALM_FULL_THR  = (2 ** ADDR_W) - 4,
    parameter int ALM_EMPTY_THR = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic                w_en,
    output logic                w_full,
    output logic [R_DATA_W-1:0] r_data,
    input  logic                r_en,
    output logic                r_empty,
    output logic [ADDR_W:0]     level
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                w_almost_full,
    output logic                r_almost_empty
`endif
);

    localparam int MIN_W   = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int W_RATIO = W_DATA_W / MIN_W;
    localparam int R_RATIO = R_DATA_W / MIN_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   c_DEPTH_LVL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_W_RATIO_LVL = (ADDR_W + 1)'(W_RATIO);
    localparam logic [ADDR_W:0]   c_R_RATIO_LVL = (ADDR_W + 1)'(R_RATIO);
    localparam logic [ADDR_W-1:0] c_W_STEP      = ADDR_W'(W_RATIO);
    localparam logic [ADDR_W-1:0] c_R_STEP      = ADDR_W'(R_RATIO);

    logic [MIN_W-1:0]    mem_q [DEPTH];
    logic [ADDR_W-1:0]   w_ptr_q;
    logic [ADDR_W-1:0]   w_ptr_d;
    logic [ADDR_W-1:0]   r_ptr_q;
    logic [ADDR_W-1:0]   r_ptr_d;
    logic [ADDR_W:0]     level_q;
    logic [ADDR_W:0]     level_d;
    logic [R_DATA_W-1:0] r_data_q;
    logic [R_DATA_W-1:0] r_data_d;
    logic                w_wr_acc;
    logic                w_rd_acc;

    // Flags derive from the registered level only, so no input reaches an output.
    assign w_full   = (c_DEPTH_LVL - level_q) < c_W_RATIO_LVL;
    assign r_empty  = level_q < c_R_RATIO_LVL;
    assign level    = level_q;
    assign r_data   = r_data_q;

    assign w_wr_acc = w_en & ~w_full;
    assign w_rd_acc = r_en & ~r_empty;

    always_comb begin
        w_ptr_d  = w_wr_acc ? w_ptr_q + c_W_STEP : w_ptr_q;
        r_ptr_d  = w_rd_acc ? r_ptr_q + c_R_STEP : r_ptr_q;
        level_d  = level_q + (w_wr_acc ? c_W_RATIO_LVL : '0)
                           - (w_rd_acc ? c_R_RATIO_LVL : '0);
        r_data_d = r_data_q;
        // Oldest minimum word lands in the least significant slice.
        if (w_rd_acc) begin
            for (int i = 0; i < R_RATIO; i++) begin
                r_data_d[i*MIN_W +: MIN_W] = mem_q[r_ptr_q + ADDR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            for (int i = 0; i < W_RATIO; i++) begin
                mem_q[w_ptr_q + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            level_q  <= '0;
            r_data_q <= '0;
        end else begin
            w_ptr_q  <= w_ptr_d;
            r_ptr_q  <= r_ptr_d;
            level_q  <= level_d;
            r_data_q <= r_data_d;
        end
    end

`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    logic w_almost_full_q;
    logic r_almost_empty_q;

    // Registered from the next level so they always agree with level.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_almost_full_q  <= 1'b0;
            r_almost_empty_q <= 1'b1;
        end else begin
            w_almost_full_q  <= int'(level_d) >= ALM_FULL_THR;
            r_almost_empty_q <= int'(level_d) <= ALM_EMPTY_THR;
        end
    end

    assign w_almost_full  = w_almost_full_q;
    assign r_almost_empty = r_almost_empty_q;
`endif

endmodule

`default_nettype wire
